ram_fifo_ctrl: RTL

- Single-clock FIFO controller that drives a DualPortRam instance as its storage.
- Accepts a valid/ready write stream and commits words through RAM port A; issues reads on RAM port B; presents data on a valid/ready read stream.
- A 2-entry output buffer hides the RAM's 1-cycle registered read latency, giving full throughput (one push and one pop per cycle).
- Sits directly upstream of the RAM (address/enable generator) and is the only master of both RAM ports.

---
 rtl/ram_fifo_ctrl.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ram_fifo_ctrl
// Brief    : Single-clock FIFO controller that uses an external dual-port RAM
//            as its storage. Writes are committed on RAM port A and reads are
//            issued on RAM port B. A 2-entry output buffer hides the RAM's
//            1-cycle registered read latency, so the FIFO can accept one push
//            and deliver one pop in every cycle.
//            Optional feature macro: RAM_FIFO_CTRL_LEVEL_EN adds registered
//            level / almost_full status outputs.
// Revision : 1.0 - initial release
// ============================================================================
module ram_fifo_ctrl #(
    parameter int DATA_WIDTH        = 8,
    parameter int ADDRESS_WIDTH     = 3,
    parameter int ALMOST_FULL_LEVEL = 2**ADDRESS_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    // write stream
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DATA_WIDTH-1:0]    s_data,
    // read stream
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_WIDTH-1:0]    m_data,
    // RAM port A (write)
    output logic                     ram_en_a,
    output logic                     ram_we_a,
    output logic [ADDRESS_WIDTH-1:0] ram_addr_a,
    output logic [DATA_WIDTH-1:0]    ram_din_a,
    // RAM port B (read)
    output logic                     ram_en_b,
    output logic                     ram_we_b,
    output logic [ADDRESS_WIDTH-1:0] ram_addr_b,
`ifdef RAM_FIFO_CTRL_LEVEL_EN
    output logic [ADDRESS_WIDTH+1:0] level,
    output logic                     almost_full,
`endif
    input  logic [DATA_WIDTH-1:0]    ram_dout_b
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // RAM word count runs 0..DEPTH, so it needs one bit more than the pointer.
    localparam logic [ADDRESS_WIDTH:0]   c_CNT_ONE  = {{ADDRESS_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDRESS_WIDTH:0]   c_CNT_FULL = {1'b1, {ADDRESS_WIDTH{1'b0}}};
    localparam logic [ADDRESS_WIDTH-1:0] c_PTR_ONE  = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [1:0]               c_BUF_ONE  = 2'd1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [ADDRESS_WIDTH-1:0] r_wr_ptr;
    logic [ADDRESS_WIDTH-1:0] r_rd_ptr;
    logic [ADDRESS_WIDTH:0]   r_ram_count;   // written, not yet read-issued
    logic                     r_rd_pending;  // read issued last cycle, data on ram_dout_b now
    logic [1:0]               r_buf_count;   // output buffer occupancy 0..2
    logic                     r_buf_head;    // index of the head entry
    logic [DATA_WIDTH-1:0]    r_buf [2];
    logic                     r_s_ready;

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic                     w_push;
    logic                     w_pop;
    logic                     w_issue;
    logic                     w_capture;
    logic                     w_tail;
    logic [2:0]               w_slots_used;
    logic [ADDRESS_WIDTH:0]   w_ram_count_next;
    logic [1:0]               w_buf_count_next;

    assign w_push    = s_valid && r_s_ready;
    assign w_pop     = m_valid && m_ready;
    assign w_capture = r_rd_pending;

    // A pending read has already claimed a buffer slot; a pop this cycle frees
    // one. A pop implies buf_count >= 1, so the subtraction never underflows.
    assign w_slots_used = {1'b0, r_buf_count} + {2'b00, r_rd_pending} - {2'b00, w_pop};

    // ram_count is registered, so a word is only read once its write edge has
    // passed -- no read-during-write case can occur on the RAM.
    assign w_issue = (r_ram_count != '0) && (w_slots_used < 3'd2);

    // Tail slot = head + count (mod 2). Capture with count == 2 cannot happen
    // because the issue rule never over-subscribes the buffer.
    assign w_tail = r_buf_head ^ r_buf_count[0];

    // Next RAM word count, including this cycle's push and read issue.
    always_comb begin
        w_ram_count_next = r_ram_count;
        if (w_push && !w_issue) begin
            w_ram_count_next = r_ram_count + c_CNT_ONE;
        end else if (!w_push && w_issue) begin
            w_ram_count_next = r_ram_count - c_CNT_ONE;
        end
    end

    // Next output-buffer occupancy, including this cycle's capture and pop.
    always_comb begin
        w_buf_count_next = r_buf_count;
        if (w_capture && !w_pop) begin
            w_buf_count_next = r_buf_count + c_BUF_ONE;
        end else if (!w_capture && w_pop) begin
            w_buf_count_next = r_buf_count - c_BUF_ONE;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign s_ready    = r_s_ready;
    assign m_valid    = (r_buf_count != 2'd0);
    assign m_data     = r_buf[r_buf_head];

    assign ram_en_a   = w_push;
    assign ram_we_a   = w_push;
    assign ram_addr_a = r_wr_ptr;
    assign ram_din_a  = s_data;

    assign ram_en_b   = w_issue;
    assign ram_we_b   = 1'b0;
    assign ram_addr_b = r_rd_ptr;

    // ------------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------------

    // Pointers, RAM word count and the read-pending flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_ram_count  <= '0;
            r_rd_pending <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_ram_count  <= w_ram_count_next;
            r_rd_pending <= w_issue;
        end
    end

    // Output buffer: capture RAM read data at the tail, advance head on pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf[0]    <= '0;
            r_buf[1]    <= '0;
            r_buf_head  <= 1'b0;
            r_buf_count <= 2'd0;
        end else begin
            if (w_capture) begin
                r_buf[w_tail] <= ram_dout_b;
            end
            if (w_pop) begin
                r_buf_head <= ~r_buf_head;
            end
            r_buf_count <= w_buf_count_next;
        end
    end

    // Registered write-side ready: depends only on the next RAM word count,
    // so there is no combinational path from m_ready to s_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s_ready <= 1'b0;
        end else begin
            r_s_ready <= (w_ram_count_next < c_CNT_FULL);
        end
    end

`ifdef RAM_FIFO_CTRL_LEVEL_EN
    // ------------------------------------------------------------------------
    // Fill level status (registered from next-state values, so it tracks the
    // current occupancy with no extra cycle of lag).
    // ------------------------------------------------------------------------
    localparam logic [ADDRESS_WIDTH+1:0] c_AF_LEVEL = ALMOST_FULL_LEVEL[ADDRESS_WIDTH+1:0];

    logic [ADDRESS_WIDTH+1:0] w_level_next;
    logic [ADDRESS_WIDTH+1:0] r_level;
    logic                     r_almost_full;

    assign w_level_next = {1'b0, w_ram_count_next}
                        + {{(ADDRESS_WIDTH+1){1'b0}}, w_issue}
                        + {{ADDRESS_WIDTH{1'b0}}, w_buf_count_next};

    // Total occupancy (RAM + pending read + buffer) and its threshold flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_level       <= '0;
            r_almost_full <= 1'b0;
        end else begin
            r_level       <= w_level_next;
            r_almost_full <= (w_level_next >= c_AF_LEVEL);
        end
    end

    assign level       = r_level;
    assign almost_full = r_almost_full;
`else
    // Threshold only matters for the status outputs; keep it referenced.
    logic w_unused_af_level;
    assign w_unused_af_level = (ALMOST_FULL_LEVEL > 0);
`endif

endmodule
`default_nettype wire
